// File: rtl/sms_bus_arbiter.sv
// Round-robin owner of a shared pull-low SMS line; every grant is followed by a TURN_CYCLES gap.
// Latency: req -> grant 1 clk from IDLE, release -> drop 1 clk; next grant TURN_CYCLES+1 clks after release.
// Backpressure: level-sensitive req waits through GRANT/TURN; SMS_ARB_TIMEOUT_EN adds MAX_GRANT revocation.
module sms_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_GRANT   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     preempt
);
  localparam int OWN_W  = $clog2(N_REQ);
  localparam int TURN_W = $clog2(TURN_CYCLES + 1);

  if (N_REQ < 2 || N_REQ > 16 || TURN_CYCLES < 1 || MAX_GRANT < 1) begin : g_param_check
    $error("sms_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

  state_t            state;
  logic [OWN_W-1:0]  last;
  logic [OWN_W-1:0]  cand;
  logic [OWN_W-1:0]  win_idx;
  logic              win_vld;
  logic [TURN_W-1:0] turn_cnt;

`ifdef SMS_ARB_TIMEOUT_EN
  localparam int GCNT_W = $clog2(MAX_GRANT + 1);
  logic [GCNT_W-1:0] gcnt;
  logic              others_req;
  assign others_req = |(req & ~grant);
`else
  assign preempt = 1'b0;
`endif

  // Walk downward so the candidate closest after 'last' is the final one assigned.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = OWN_W'((int'(last) + i) % N_REQ);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      last     <= OWN_W'(N_REQ - 1);
      turn_cnt <= '0;
`ifdef SMS_ARB_TIMEOUT_EN
      gcnt     <= '0;
      preempt  <= 1'b0;
`endif
    end else begin
`ifdef SMS_ARB_TIMEOUT_EN
      preempt <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            grant <= N_REQ'(1) << win_idx;
            owner <= win_idx;
            last  <= win_idx;
            busy  <= 1'b1;
            state <= ST_GRANT;
`ifdef SMS_ARB_TIMEOUT_EN
            gcnt  <= GCNT_W'(1);
`endif
          end
        end
        ST_GRANT: begin
          if (!req[owner]) begin
            grant    <= '0;
            turn_cnt <= TURN_W'(TURN_CYCLES - 1);
            state    <= ST_TURN;
          end
`ifdef SMS_ARB_TIMEOUT_EN
          // Revoke only when someone else is actually waiting for the line.
          else if (gcnt == GCNT_W'(MAX_GRANT) && others_req) begin
            grant    <= '0;
            turn_cnt <= TURN_W'(TURN_CYCLES - 1);
            state    <= ST_TURN;
            preempt  <= 1'b1;
          end else if (gcnt != GCNT_W'(MAX_GRANT)) begin
            gcnt <= gcnt + 1'b1;
          end
`endif
        end
        ST_TURN: begin
          if (turn_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sms_bus_arbiter.sv
// Bench for sms_bus_arbiter (N_REQ=4, TURN_CYCLES=2, MAX_GRANT=8); follows SMS_ARB_TIMEOUT_EN if defined.
module tb_sms_bus_arbiter;
  localparam int N     = 4;
  localparam int TURN  = 2;
  localparam int MAXG  = 8;
`ifdef SMS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         busy;
  logic         preempt;

  int n_chk  = 0;
  int n_pass = 0;

  sms_bus_arbiter #(.N_REQ(N), .TURN_CYCLES(TURN), .MAX_GRANT(MAXG)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .owner(owner), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  // Reference: current holder (-1 = nobody), gap cycles still owed before arbitration, cycles held.
  int m_cur, m_last, m_gap, m_hold, m_owner;
  bit m_pre;

  function automatic void model_reset();
    m_cur = -1; m_last = N - 1; m_gap = 0; m_hold = 0; m_owner = 0; m_pre = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    logic [N-1:0] mine;
    bit others, found;
    int idx;
    m_pre = 1'b0;
    if (m_cur >= 0) begin
      mine   = N'(1) << m_cur;
      others = (r & ~mine) != '0;
      if ((r & mine) == '0) begin
        m_cur = -1; m_gap = TURN;
      end else if (TO_EN && m_hold >= MAXG && others) begin
        m_cur = -1; m_gap = TURN; m_pre = 1'b1;
      end else if (m_hold < MAXG) begin
        m_hold++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && r[idx]) begin
          found = 1'b1; m_cur = idx; m_last = idx; m_owner = idx; m_hold = 1;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] m_grant();
    return (m_cur >= 0) ? (N'(1) << m_cur) : '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    model_reset();
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_preempt", preempt, 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Apply r for one edge, advance the reference, compare every output.
  task automatic cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    chk("grant", grant, m_grant());
    chk("owner", owner, m_owner);
    chk("busy", busy, (m_cur >= 0 || m_gap > 0));
    chk("preempt", preempt, m_pre);
    chk("onehot", ($countones(grant) <= 1), 1);
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] g;
    logic [1:0]   o;
    logic         b;
  } vec_t;

  vec_t vt[20];

  initial begin
    int order[$];
    int exp_order[5];
    int held, zero_run;
    logic [N-1:0] r, prev_g;

    vt[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vt[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vt[2]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vt[3]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vt[4]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vt[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b1};
    vt[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b1};
    vt[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vt[8]  = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    vt[9]  = '{4'b0000, 4'b0000, 2'd1, 1'b1};
    vt[10] = '{4'b0110, 4'b0000, 2'd1, 1'b1};
    vt[11] = '{4'b0110, 4'b0000, 2'd1, 1'b0};
    vt[12] = '{4'b0110, 4'b0100, 2'd2, 1'b1};
    vt[13] = '{4'b0010, 4'b0000, 2'd2, 1'b1};
    vt[14] = '{4'b0010, 4'b0000, 2'd2, 1'b1};
    vt[15] = '{4'b0010, 4'b0000, 2'd2, 1'b0};
    vt[16] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    vt[17] = '{4'b0000, 4'b0000, 2'd1, 1'b1};
    vt[18] = '{4'b0000, 4'b0000, 2'd1, 1'b1};
    vt[19] = '{4'b0000, 4'b0000, 2'd1, 1'b0};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(vt[i].r);
      chk($sformatf("vec%0d_grant", i), grant, vt[i].g);
      chk($sformatf("vec%0d_owner", i), owner, vt[i].o);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].b);
    end

    // All cards requesting, each owner releases after 3 granted cycles.
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    held = 0; zero_run = 0; prev_g = '0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      r = 4'b1111;
      if (grant != '0 && held >= 3) r = 4'b1111 & ~grant;
      cycle(r);
      if (grant != '0) begin
        if (prev_g == '0) begin
          order.push_back(int'(owner));
          if (order.size() > 1) chk("rr_gap", zero_run, TURN + 1);
          held = 0;
        end
        held++;
        zero_run = 0;
      end else begin
        zero_run++;
      end
      prev_g = grant;
    end
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < order.size(); i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    cycle('0); cycle('0); cycle('0);

    // Asynchronous reset while card 2 owns the line.
    do_reset();
    cycle(4'b0100); cycle(4'b0100); cycle(4'b0100);
    chk("pre_reset_grant", grant, 4'b0100);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_owner", owner, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(4'b0100);
    chk("post_rst_grant", grant, 4'b0100);
    chk("post_rst_owner", owner, 2);
    cycle('0); cycle('0); cycle('0);

    // Card 0 holds while card 1 waits: revoked at edge 8 only with timeout built in.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(4'b0011);
      chk($sformatf("to_grant%0d", c), grant,
          (TO_EN && c >= 8) ? ((c == 11) ? 4'b0010 : 4'b0000) : 4'b0001);
      chk($sformatf("to_preempt%0d", c), preempt, (TO_EN && c == 8));
    end
    cycle('0); cycle('0); cycle('0); cycle('0);

    // Lone requester is never preempted.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(4'b1000);
      chk("solo_grant", grant, 4'b1000);
      chk("solo_preempt", preempt, 0);
    end
    cycle('0); cycle('0); cycle('0);

    // Random level-sensitive requests against the reference.
    do_reset();
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(5) == 0) r[b] = ~r[b];
      cycle(r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
